// File: rtl/guess_round_ctrl.sv
// Round sequencer for the number-guessing game: latches the BCD target, runs the round FSM,
// owns the BCD countdown, lives LED bar, hint code and beeper. All outputs registered.
// Enter -> state change 3 cycles; optional wrong-guess chirp enabled by GUESS_MISS_BEEP_EN.
module guess_round_ctrl #(
  parameter int unsigned MAX_TRIES  = 8,
  parameter int unsigned TIME_TENS  = 9,
  parameter int unsigned TIME_ONES  = 9,
  parameter int unsigned BEEP_TICKS = 3
) (
  input  logic       CLK,
  input  logic       Clear_n,
  input  logic       sec_tick,
  input  logic       Enter,
  input  logic [3:0] num1,
  input  logic [3:0] num2,
  input  logic [3:0] rnd_tens,
  input  logic [3:0] rnd_ones,
  output logic [3:0] tgt_tens,
  output logic [3:0] tgt_ones,
  output logic [3:0] time_tens,
  output logic [3:0] time_ones,
  output logic [2:0] hint,
  output logic [7:0] lives,
  output logic       beep,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARM   = 3'd1,
    S_PLAY  = 3'd2,
    S_CHECK = 3'd3,
    S_WIN   = 3'd4,
    S_LOSE  = 3'd5
  } state_t;

  localparam logic [3:0] TT_RST = 4'(TIME_TENS);
  localparam logic [3:0] TO_RST = 4'(TIME_ONES);
  localparam logic [3:0] TRIES_MAX = 4'(MAX_TRIES);
  localparam logic [7:0] BEEP_LEN = 8'(BEEP_TICKS);

  state_t     state_q, state_d;
  logic       sync1_q, sync2_q, sync3_q;
  logic [3:0] tgt_t_q, tgt_t_d, tgt_o_q, tgt_o_d;
  logic [3:0] tm_t_q, tm_t_d, tm_o_q, tm_o_d;
  logic [2:0] hint_q, hint_d;
  logic [7:0] lives_q, lives_d;
  logic       beep_q, beep_d;
  logic [7:0] bcnt_q, bcnt_d;
  logic [3:0] tries_q, tries_d;

  logic       ent_p;
  logic [6:0] guess_v, target_v;
  logic       time_zero, dec_zero;
  logic [3:0] dec_t, dec_o;

  // Rising edge of the synchronized button level.
  assign ent_p = sync2_q & ~sync3_q;

  // Guess/target as binary values and the BCD decrement of the countdown.
  always_comb begin
    guess_v   = 7'({3'b000, num1} * 7'd10) + {3'b000, num2};
    target_v  = 7'({3'b000, tgt_t_q} * 7'd10) + {3'b000, tgt_o_q};
    time_zero = (tm_t_q == 4'd0) && (tm_o_q == 4'd0);
    if (tm_o_q == 4'd0) begin
      dec_o = 4'd9;
      dec_t = tm_t_q - 4'd1;
    end else begin
      dec_o = tm_o_q - 4'd1;
      dec_t = tm_t_q;
    end
    dec_zero = (dec_t == 4'd0) && (dec_o == 4'd0);
  end

  // Next-state and datapath updates; WIN/LOSE entry actions are applied after the case.
  always_comb begin
    state_d = state_q;
    tgt_t_d = tgt_t_q;
    tgt_o_d = tgt_o_q;
    tm_t_d  = tm_t_q;
    tm_o_d  = tm_o_q;
    hint_d  = hint_q;
    lives_d = lives_q;
    beep_d  = beep_q;
    bcnt_d  = bcnt_q;
    tries_d = tries_q;
    case (state_q)
      S_IDLE: begin
        if (ent_p) state_d = S_ARM;
      end
      S_ARM: begin
        tgt_t_d = (rnd_tens > 4'd9) ? 4'd9 : rnd_tens;
        tgt_o_d = (rnd_ones > 4'd9) ? 4'd9 : rnd_ones;
        tm_t_d  = TT_RST;
        tm_o_d  = TO_RST;
        lives_d = 8'hFF;
        tries_d = 4'd0;
        hint_d  = 3'b000;
        beep_d  = 1'b0;
        state_d = S_PLAY;
      end
      S_PLAY: begin
        // A chirp (if any) lasts until the next second strobe.
        if (sec_tick) beep_d = 1'b0;
        if (sec_tick && !time_zero) begin
          tm_t_d = dec_t;
          tm_o_d = dec_o;
        end
        // A press wins over a timeout; CHECK re-evaluates the countdown.
        if (ent_p) state_d = S_CHECK;
        else if (time_zero || (sec_tick && dec_zero)) state_d = S_LOSE;
      end
      S_CHECK: begin
        if ((num1 > 4'd9) || (num2 > 4'd9)) begin
          state_d = S_PLAY;
        end else if (guess_v == target_v) begin
          state_d = S_WIN;
        end else if (time_zero) begin
          state_d = S_LOSE;
        end else begin
          tries_d = tries_q + 4'd1;
          lives_d[tries_q[2:0]] = 1'b0;
          if (tries_d >= TRIES_MAX) begin
            state_d = S_LOSE;
          end else begin
            hint_d  = (target_v > guess_v) ? 3'b001 : 3'b010;
            state_d = S_PLAY;
`ifdef GUESS_MISS_BEEP_EN
            beep_d  = 1'b1;
`endif
          end
        end
      end
      S_WIN, S_LOSE: begin
        if (beep_q && sec_tick) begin
          if (bcnt_q <= 8'd1) beep_d = 1'b0;
          bcnt_d = bcnt_q - 8'd1;
        end
        if (ent_p) begin
          state_d = S_IDLE;
          beep_d  = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if ((state_d == S_WIN) && (state_q != S_WIN)) begin
      hint_d = 3'b011;
      beep_d = 1'b1;
      bcnt_d = BEEP_LEN;
    end
    if ((state_d == S_LOSE) && (state_q != S_LOSE)) begin
      hint_d  = 3'b111;
      lives_d = 8'h00;
      beep_d  = 1'b1;
      bcnt_d  = BEEP_LEN;
    end
  end

  // State register.
  always_ff @(posedge CLK or negedge Clear_n) begin
    if (!Clear_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Synchronizer, target, countdown, hint, lives and beeper registers.
  always_ff @(posedge CLK or negedge Clear_n) begin
    if (!Clear_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
      tgt_t_q <= 4'd0;
      tgt_o_q <= 4'd0;
      tm_t_q  <= TT_RST;
      tm_o_q  <= TO_RST;
      hint_q  <= 3'b000;
      lives_q <= 8'hFF;
      beep_q  <= 1'b0;
      bcnt_q  <= 8'd0;
      tries_q <= 4'd0;
    end else begin
      sync1_q <= Enter;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      tgt_t_q <= tgt_t_d;
      tgt_o_q <= tgt_o_d;
      tm_t_q  <= tm_t_d;
      tm_o_q  <= tm_o_d;
      hint_q  <= hint_d;
      lives_q <= lives_d;
      beep_q  <= beep_d;
      bcnt_q  <= bcnt_d;
      tries_q <= tries_d;
    end
  end

  assign tgt_tens  = tgt_t_q;
  assign tgt_ones  = tgt_o_q;
  assign time_tens = tm_t_q;
  assign time_ones = tm_o_q;
  assign hint      = hint_q;
  assign lives     = lives_q;
  assign beep      = beep_q;
  assign state     = state_q;

endmodule
